// File: rtl/xdfil_mc.sv
// xdfil_mc: buffers scheduler commands in xdfilram as a circular FIFO and
// dispatches them in order as tagged requests on per-channel DMA ports.
module xdfil_mc #(
  parameter int RAM_DEPTH = 128,
  parameter int RAM_WIDTH = 32,
  parameter int NUM_CH = 2,
  parameter int TAG_W = 8,
  parameter int HIGH_WM = 96,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int REQ_W = RAM_WIDTH + TAG_W
) (
  input  logic                             xdfil_clk,
  input  logic                             xdfil_rst_n,
  input  logic                             sch2xdfil_valid,
  input  logic [RAM_WIDTH-1:0]             sch2xdfil_data,
  output logic                             sch2xdfil_stall,
  output logic [NUM_CH-1:0]                xdfil2dma_req_valid,
  output logic [NUM_CH-1:0][REQ_W-1:0]     xdfil2dma_req_data,
  input  logic [NUM_CH-1:0]                xdfil2dma_req_stall,
  output logic                             xdfilram_wen,
  output logic [AW-1:0]                    xdfilram_waddr,
  output logic [RAM_WIDTH-1:0]             xdfilram_wdata,
  output logic                             xdfilram_ren,
  output logic [AW-1:0]                    xdfilram_raddr,
  input  logic [RAM_WIDTH-1:0]             xdfilram_rdata,
  input  logic                             xdfil_intr_clr,
  output logic                             xdfil_intr
);
  typedef enum logic [1:0] {IDLE, RD, WAIT, SEND} state_t;
  state_t state_q, state_d;
  logic [AW:0] used_q, used_d, count_q, count_d;
  logic [AW-1:0] wptr_q, rptr_q, waddr_q;
  logic [RAM_WIDTH-1:0] wdata_q;
  logic wen_q, err_q, err_d, intr_q;
  logic [CH_W-1:0] ch_q, rd_ch;
  logic [NUM_CH-1:0][TAG_W-1:0] tag_q;
  logic [NUM_CH-1:0][REQ_W-1:0] req_data_q;
  logic push, pop, bad, accept;
  always_comb begin
    sch2xdfil_stall = used_q == (AW+1)'(RAM_DEPTH);
    push = sch2xdfil_valid && !sch2xdfil_stall;
    rd_ch = xdfilram_rdata[RAM_WIDTH-1 -: CH_W];
    bad = state_q == WAIT && {1'b0, rd_ch} >= (CH_W+1)'(NUM_CH);
    accept = state_q == SEND && !xdfil2dma_req_stall[ch_q];
    pop = bad || accept;
    state_d = state_q == IDLE ? (count_q != '0 ? RD : IDLE) :
              state_q == RD   ? WAIT :
              state_q == WAIT ? (bad ? IDLE : SEND) :
                                (accept ? IDLE : SEND);
    used_d = used_q + (AW+1)'(push) - (AW+1)'(pop);
    // count trails used by one cycle so a read never targets a write still in flight
    count_d = count_q + (AW+1)'(wen_q) - (AW+1)'(pop);
    err_d = (err_q && !xdfil_intr_clr) || bad;
  end
  assign xdfil2dma_req_valid = state_q == SEND ? NUM_CH'(1) << ch_q : '0;
  assign xdfil2dma_req_data = req_data_q;
  assign xdfilram_wen = wen_q;
  assign xdfilram_waddr = waddr_q;
  assign xdfilram_wdata = wdata_q;
  assign xdfilram_ren = state_q == RD;
  assign xdfilram_raddr = rptr_q;
  assign xdfil_intr = intr_q;
  always_ff @(posedge xdfil_clk or negedge xdfil_rst_n) begin
    if (!xdfil_rst_n) begin
      state_q <= IDLE;
      used_q <= '0;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
      err_q <= 1'b0;
      intr_q <= 1'b0;
      ch_q <= '0;
      tag_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q <= state_d;
      used_q <= used_d;
      count_q <= count_d;
      wen_q <= push;
      if (push) begin
        waddr_q <= wptr_q;
        wdata_q <= sch2xdfil_data;
        wptr_q <= wptr_q + AW'(1);
      end
      rptr_q <= rptr_q + AW'(pop);
      err_q <= err_d;
      intr_q <= err_q || used_q >= (AW+1)'(HIGH_WM);
      if (state_q == WAIT && !bad) begin
        ch_q <= rd_ch;
        req_data_q[rd_ch] <= {xdfilram_rdata, tag_q[rd_ch]};
      end
      if (accept) tag_q[ch_q] <= tag_q[ch_q] + TAG_W'(1);
    end
  end
endmodule

// File: doc/xdfil_mc.md
Name: xdfil_mc

Overview:
- Multi-channel successor of the xdfil filter/dispatch block.
- Accepts scheduler commands and buffers them in the external xdfilram as a circular FIFO.
- Reads them back in order and dispatches each as a tagged DMA request on one of NUM_CH request channels, selected by a field in the command.
- Raises a level interrupt on bad-channel commands (sticky) or when the buffer reaches a high-water mark.

Parameters:
- RAM_DEPTH, 128, FIFO entries in xdfilram (power of 2, >=4).
- RAM_WIDTH, 32, xdfilram word width; equals command width.
- NUM_CH, 2, DMA request channels (1..8); CH_W = max(1, $clog2(NUM_CH)).
- TAG_W, 8, per-channel sequence tag width.
- HIGH_WM, 96, occupancy at or above which the watermark interrupt source is active (1..RAM_DEPTH).
- Derived: AW = $clog2(RAM_DEPTH); REQ_W = RAM_WIDTH + TAG_W.

Ports:
- xdfil_clk  in  1  clock.
- xdfil_rst_n  in  1  reset.
- sch2xdfil_valid  in  1  command valid.
- sch2xdfil_data  in  RAM_WIDTH  command; channel field = data[RAM_WIDTH-1 -: CH_W].
- sch2xdfil_stall  out  1  backpressure to scheduler.
- xdfil2dma_req_valid  out  NUM_CH  per-channel request valid.
- xdfil2dma_req_data  out  NUM_CH x REQ_W  per-channel {command, tag}.
- xdfil2dma_req_stall  in  NUM_CH  per-channel backpressure.
- xdfilram_wen  out  1  RAM write enable.
- xdfilram_waddr  out  AW  RAM write address.
- xdfilram_wdata  out  RAM_WIDTH  RAM write data.
- xdfilram_ren  out  1  RAM read enable.
- xdfilram_raddr  out  AW  RAM read address.
- xdfilram_rdata  in  RAM_WIDTH  RAM read data, valid 1 cycle after ren.
- xdfil_intr_clr  in  1  pulse; clears the sticky error.
- xdfil_intr  out  1  level interrupt.

Interface (already decided): one clock, xdfil_clk; reset xdfil_rst_n is asynchronous and active-low.

Behaviour:
- Handshake: a transfer occurs when valid && !stall.
  - Producer holds valid and data stable while stalled.
  - The block never drops valid before acceptance.
- Reset values:
  - All outputs 0, except sch2xdfil_stall = 0.
  - wptr = rptr = 0; used = 0; count = 0; all tags = 0; err_sticky = 0; FSM = IDLE.
  - RAM contents are don't-care after reset.
- Write side:
  - sch2xdfil_stall = (used == RAM_DEPTH), combinational from used.
  - On acceptance at cycle T: used++ at T+1.
  - Registered wen = 1, waddr = wptr, wdata = command in cycle T+1; wptr++ (wraps mod RAM_DEPTH).
  - count (readable entries) increments at end of T+1.
- Read FSM states IDLE -> RD -> WAIT -> SEND:
  - IDLE: if count != 0, go to RD.
  - RD: ren = 1, raddr = rptr for exactly one cycle; go to WAIT.
  - WAIT: capture rdata and channel field.
    - If channel >= NUM_CH: set err_sticky, pop, go to IDLE. No request is issued.
    - Otherwise go to SEND.
  - SEND: req_valid[ch] = 1, req_data[ch] = {cmd, tag[ch]}. On acceptance: tag[ch]++ (wraps 2^TAG_W-1 -> 0), pop, go to IDLE.
  - Pop: rptr++ (wrap), count--, used--, all on the same edge.
  - Only one channel valid at a time; all other channels' valid = 0 and their data hold their last values.
- Latency:
  - Accept at T with FIFO empty and FSM idle: ren at T+3, req_valid at T+5.
  - Minimum 4 cycles per dispatched entry.
- Simultaneous push and pop: used and count update by the net change. The full flag uses the pre-edge used, so a push is refused when full even if a pop occurs in the same cycle.
- Hazard: a read address never equals a pending write address, because count lags used by one cycle.
- Interrupt: xdfil_intr = err_sticky | (used >= HIGH_WM), registered, 1-cycle delay.
  - xdfil_intr_clr clears err_sticky.
  - A new error in the same cycle as clr wins (err_sticky stays 1).
  - The watermark source is not sticky.
- Reset mid-operation: all state is discarded immediately (async). Any in-flight request valid drops to 0 with no acceptance.

Test Plan:
- Single command 0x0000_1234 (ch 0), no stalls -> ren at T+3 (raddr 0), req_valid[0] at T+5, req_data[0] = {0x0000_1234, 8'h00}; subsequent ch-0 command carries tag 0x01.
- 128 commands with all req stalls held high -> sch2xdfil_stall asserts once used = 128, 129th held until one pop; xdfil_intr high from used = 96; wptr wraps to 0.
- NUM_CH = 3, command 0xC000_0000 (ch field 3) -> no req_valid, entry popped, xdfil_intr = 1 and stays until xdfil_intr_clr; clr coincident with a second bad command -> stays 1.
- Ch 1 stalled for 10 cycles during SEND -> req_valid[1] and req_data[1] stable all 10 cycles, single acceptance, tag[1] increments once; ch 0 valid stays 0.
- 256 ch-0 commands -> tags 0x00..0xFF then 0x00; output order equals input order.
- Assert xdfil_rst_n low while in SEND with 5 entries buffered -> all outputs 0 in the same cycle; after release, used = 0, no requests issued.
